board_engine: RTL

//  2048 game-state engine. It owns the 4x4 board and applies direction commands (slide and merge).

---
 rtl/board_engine.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/board_engine.sv
// 2048 game-state engine: owns the 4x4 board, applies slide/merge moves,
// spawns new tiles from an LFSR and classifies the board as playing/won/lost.
// matrix and mode are registered and only change when a result is committed.
module board_engine #(
   parameter int unsigned WIN_EXP   = 11,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        dir_valid,
   input  logic [1:0]  dir,
   output logic        dir_ready,
   input  logic        load_en,
   input  logic [63:0] load_matrix,
   output logic [63:0] matrix,
   output logic [3:0]  mode,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_SPAWN, S_EVAL, S_PLAY, S_MOVE, S_CHECK, S_WON, S_LOST
   } state_t;

   state_t      state;
   logic [15:0] lfsr;
   logic        lfsr_fb;
   logic [63:0] work;
   logic [63:0] work_moved;
   logic [15:0] line_in;
   logic [15:0] line_out;
   logic [1:0]  move_dir;
   logic [1:0]  line_cnt;
   logic [3:0]  probe;
   logic        spawn_second;
   logic [3:0]  spawn_val;

   // Merged tile value saturates at the largest encodable exponent.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'd15) ? 4'd15 : v + 4'd1;
   endfunction

   // Board cell {row,col} holding position pos of line ln, position 0 at the destination edge.
   function automatic logic [3:0] cell_idx(input logic [1:0] d, input logic [1:0] ln,
                                           input logic [1:0] pos);
      logic [1:0] r;
      logic [1:0] c;
      case (d)
         2'd0:    begin r = pos;         c = ln;          end
         2'd1:    begin r = 2'd3 - pos;  c = ln;          end
         2'd2:    begin r = ln;          c = pos;         end
         default: begin r = ln;          c = 2'd3 - pos;  end
      endcase
      return {r, c};
   endfunction

   // Slide one line toward position 0, merging each equal pair at most once.
   function automatic logic [15:0] merge_line(input logic [15:0] ln);
      logic [19:0] cmp;
      logic [15:0] res;
      logic [2:0]  k;
      logic [2:0]  oi;
      logic        skip;
      cmp  = '0;
      res  = '0;
      k    = '0;
      oi   = '0;
      skip = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (ln[4*i +: 4] != 4'd0) begin
            cmp[4*k +: 4] = ln[4*i +: 4];
            k = k + 3'd1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (cmp[4*i +: 4] != 4'd0) begin
            if (cmp[4*i +: 4] == cmp[4*i+4 +: 4]) begin
               res[4*oi +: 4] = sat_inc(cmp[4*i +: 4]);
               skip = 1'b1;
            end else begin
               res[4*oi +: 4] = cmp[4*i +: 4];
            end
            oi = oi + 3'd1;
         end
      end
      return res;
   endfunction

   function automatic logic board_won(input logic [63:0] b);
      logic w;
      w = 1'b0;
      for (int i = 0; i < 16; i++)
         if ({28'd0, b[4*i +: 4]} >= WIN_EXP) w = 1'b1;
      return w;
   endfunction

   // Lost when the board is full and no horizontal or vertical neighbours match.
   function automatic logic board_lost(input logic [63:0] b);
      logic l;
      l = 1'b1;
      for (int i = 0; i < 16; i++)
         if (b[4*i +: 4] == 4'd0) l = 1'b0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (b[4*(4*r+c) +: 4] == b[4*(4*r+c+1) +: 4]) l = 1'b0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++)
            if (b[4*(4*r+c) +: 4] == b[4*(4*r+c+4) +: 4]) l = 1'b0;
      return l;
   endfunction

   assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign spawn_val = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;

   // Work board with the current move line slid and merged.
   always_comb begin
      line_in = '0;
      for (int j = 0; j < 4; j++)
         line_in[4*j +: 4] = work[4*cell_idx(move_dir, line_cnt, 2'(j)) +: 4];
      line_out   = merge_line(line_in);
      work_moved = work;
      for (int j = 0; j < 4; j++)
         work_moved[4*cell_idx(move_dir, line_cnt, 2'(j)) +: 4] = line_out[4*j +: 4];
   end

   // Game FSM with free-running spawn LFSR; outputs update only at commit points.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         lfsr         <= LFSR_SEED;
         work         <= '0;
         matrix       <= '0;
         mode         <= 4'd0;
         dir_ready    <= 1'b0;
         busy         <= 1'b0;
         move_dir     <= 2'd0;
         line_cnt     <= 2'd0;
         probe        <= 4'd0;
         spawn_second <= 1'b0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};
         case (state)
            S_IDLE, S_WON, S_LOST: begin
               if (start) begin
                  state <= S_CLEAR;
                  busy  <= 1'b1;
               end
            end
            S_CLEAR: begin
               work         <= '0;
               spawn_second <= 1'b1;
               probe        <= lfsr[3:0];
               state        <= S_SPAWN;
            end
            S_SPAWN: begin
               if (work[4*probe +: 4] == 4'd0) begin
                  work[4*probe +: 4] <= spawn_val;
                  if (spawn_second) begin
                     // New game: a second tile follows, probing from a fresh index.
                     spawn_second <= 1'b0;
                     probe        <= lfsr[3:0];
                  end else begin
                     state <= S_EVAL;
                  end
               end else begin
                  probe <= probe + 4'd1;
               end
            end
            S_EVAL: begin
               matrix <= work;
               busy   <= 1'b0;
               if (board_won(work)) begin
                  mode  <= 4'd2;
                  state <= S_WON;
               end else if (board_lost(work)) begin
                  mode  <= 4'd3;
                  state <= S_LOST;
               end else begin
                  mode      <= 4'd1;
                  dir_ready <= 1'b1;
                  state     <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (start) begin
                  state     <= S_CLEAR;
                  busy      <= 1'b1;
                  dir_ready <= 1'b0;
               end else if (load_en) begin
                  matrix <= load_matrix;
               end else if (dir_valid) begin
                  move_dir  <= dir;
                  work      <= matrix;
                  line_cnt  <= 2'd0;
                  busy      <= 1'b1;
                  dir_ready <= 1'b0;
                  state     <= S_MOVE;
               end
            end
            S_MOVE: begin
               work     <= work_moved;
               line_cnt <= line_cnt + 2'd1;
               if (line_cnt == 2'd3) state <= S_CHECK;
            end
            S_CHECK: begin
               if (work == matrix) begin
                  // Ineffective move: no spawn, board stays as displayed.
                  busy      <= 1'b0;
                  dir_ready <= 1'b1;
                  state     <= S_PLAY;
               end else begin
                  spawn_second <= 1'b0;
                  probe        <= lfsr[3:0];
                  state        <= S_SPAWN;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
